// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline register indices/controls in, stall/flush/forward out.
// Purely a signal bundle; no storage, no latency.
// The controller side never backpressures; the pipeline obeys stall/flush every cycle.
interface hazard_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 32
);
    logic [ADDRESS_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]               ResultSrcE;
    logic                     RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic                     StallF, StallD, StallE, StallM;
    logic                     FlushD, FlushE, FlushW;
    logic [1:0]               ForwardAE, ForwardBE;
    logic                     MemErr;
    logic [CNT_WIDTH-1:0]     StallCycles, LoadUseCount;

    // Pipeline side: supplies register indices and stage controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCycles, LoadUseCount
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCycles, LoadUseCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use, branch flush, memory-wait freeze.
// Stall/flush/forward are combinational (0 cycles); FSM, MemErr and counters are registered.
// A pending data-memory access freezes every stage; a timeout freezes it until reset.
module hazard_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 32,
    parameter int TIMEOUT       = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hz
);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [ADDRESS_WIDTH-1:0] X0 = '0;

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    state_t               state, state_nxt;
    logic [WCW-1:0]       wait_cnt, wait_cnt_nxt;
    logic                 err_set, mem_err;
    logic                 lw_stall, mem_stall, any_stall;
    logic                 stall_f, stall_d, stall_e, stall_m;
    logic [CNT_WIDTH-1:0] stall_cycles, load_use_count;

    // Hazard detection: load-use in Decode, and memory not ready (or locked up after timeout).
    always_comb begin
        lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != X0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        mem_stall = (hz.MemReqM && !hz.MemReadyM) || (state == S_ERROR);
    end

    // Stall/flush/forward generation; memory freeze wins, reset forces a bubble everywhere.
    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (rst) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushW = 1'b1;
        end else begin
            if (hz.RegWriteM && hz.RdM != X0 && hz.RdM == hz.Rs1E)      hz.ForwardAE = 2'b10;
            else if (hz.RegWriteW && hz.RdW != X0 && hz.RdW == hz.Rs1E) hz.ForwardAE = 2'b01;
            if (hz.RegWriteM && hz.RdM != X0 && hz.RdM == hz.Rs2E)      hz.ForwardBE = 2'b10;
            else if (hz.RegWriteW && hz.RdW != X0 && hz.RdW == hz.Rs2E) hz.ForwardBE = 2'b01;
            if (mem_stall) begin
                // A taken branch sits frozen in E and is acted on once memory releases.
                stall_f   = 1'b1;
                stall_d   = 1'b1;
                stall_e   = 1'b1;
                stall_m   = 1'b1;
                hz.FlushW = 1'b1;
            end else begin
                stall_f   = lw_stall;
                stall_d   = lw_stall;
                hz.FlushE = lw_stall || hz.PCSrcE;
                hz.FlushD = hz.PCSrcE;
            end
        end
        any_stall = stall_f || stall_d || stall_e || stall_m;
    end

    assign hz.StallF       = stall_f;
    assign hz.StallD       = stall_d;
    assign hz.StallE       = stall_e;
    assign hz.StallM       = stall_m;
    assign hz.MemErr       = mem_err;
    assign hz.StallCycles  = stall_cycles;
    assign hz.LoadUseCount = load_use_count;

    // Memory wait FSM next state: wait_cnt counts stalled cycles already spent in the wait.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        case (state)
            S_RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_nxt    = S_MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            S_MEM_WAIT: begin
                if (hz.MemReadyM || !hz.MemReqM) begin
                    state_nxt    = S_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WCW'(TIMEOUT)) begin
                    state_nxt = S_ERROR;
                    err_set   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            default: begin
                state_nxt = S_ERROR;
            end
        endcase
    end

    // FSM state, sticky error flag and wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_RUN;
            wait_cnt       <= '0;
            mem_err        <= 1'b0;
            stall_cycles   <= '0;
            load_use_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set)
                mem_err <= 1'b1;
            if (any_stall)
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (lw_stall && !mem_stall)
                load_use_count <= load_use_count + CNT_WIDTH'(1);
        end
    end
endmodule
